// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: hazard detection and forwarding selects beside the ID stage.
// Tracks in-flight destinations EX..WB; drives load-use stall and perf counters.
module pipe_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         id_dst,
    input  logic                          id_regwrite,
    input  logic                          id_memread,
    input  logic                          flush,
    input  logic                          stat_clr,
    output logic                          stall,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              fwd_cnt
);

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] dst;
        logic                  rw;
        logic                  ld;
    } entry_t;

    entry_t                ent [DEPTH];
    logic [SEL_W-1:0]      sel [NUM_SRC];
    logic [NUM_SRC-1:0]    ld_hit;
    logic [REG_ADDR_W-1:0] src;
    logic                  take;
    logic                  fwd_any;

    // Scan oldest to youngest so the lowest matching index wins.
    always_comb begin
        src = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sel[k]    = '0;
            ld_hit[k] = 1'b0;
            src       = id_src_addr[k*REG_ADDR_W +: REG_ADDR_W];
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (id_valid && id_src_used[k] && ent[i].v && ent[i].rw &&
                    ent[i].dst != '0 && ent[i].dst == src) begin
                    sel[k]    = SEL_W'(i + 1);
                    ld_hit[k] = ent[i].ld && (i < LOAD_LAT);
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_pack
        assign fwd_sel[k*SEL_W +: SEL_W] = sel[k];
    end

    assign stall   = id_valid && !flush && (|ld_hit);
    assign take    = id_valid && !stall && !flush;
    assign fwd_any = |fwd_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                ent[i] <= ent[i-1];
            end
            ent[0] <= take ? {1'b1, id_dst, id_regwrite, id_memread} : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (fwd_any && fwd_cnt != '1) begin
                fwd_cnt <= fwd_cnt + 1'b1;
            end
        end
    end

endmodule
